// File: rtl/tcp_tx_byte_packer_pkg.sv
// Shared definitions for the TCP TX byte packer: segment sizing, FSM states
// and tkeep helpers.
package tcp_tx_byte_packer_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pk_state_e;

    function automatic int seg_beats(input int seg_len);
        return seg_len / 8;
    endfunction

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, keep[i]};
        end
        return c;
    endfunction

    // Contiguous low-byte mask for a byte count of 0..8.
    function automatic logic [7:0] count_to_keep(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    function automatic logic keep_contig(input logic [7:0] keep);
        return keep == count_to_keep(keep_count(keep));
    endfunction

endpackage

// File: rtl/tcp_tx_byte_packer_out_reg.sv
// One-deep AXI-Stream output register: accepts a load only while free and
// holds data stable until the downstream handshake.
module tcp_axis_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic                  s_aclk,
    input  logic                  s_aresetn,
    input  logic                  load,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic [DATA_W/8-1:0]   ld_keep,
    input  logic                  ld_last,
    output logic                  free,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast
);

    assign free = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load && free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_data;
            m_axis_tkeep  <= ld_keep;
            m_axis_tlast  <= ld_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tcp_tx_byte_packer.sv
// Repacks sparse 64-bit application beats into dense beats and cuts them into
// fixed-length TCP segments, flushing residue on tlast or idle timeout.
module tcp_tx_byte_packer #(
    parameter int TCP_DATA_LENGTH = 1456,
    parameter int FLUSH_TIMEOUT   = 1024
) (
    input  logic        s_aclk,
    input  logic        s_aresetn,
    input  logic        app_axis_tvalid,
    output logic        app_axis_tready,
    input  logic [63:0] app_axis_tdata,
    input  logic [7:0]  app_axis_tkeep,
    input  logic        app_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic [31:0] seg_count,
    output logic        keep_err
);
    import tcp_tx_byte_packer_pkg::*;

    localparam int SEG_BEATS = seg_beats(TCP_DATA_LENGTH);
    localparam int BEAT_W    = $clog2(SEG_BEATS + 1);
    localparam int IDLE_W    = $clog2(FLUSH_TIMEOUT + 2);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(SEG_BEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_TIMEOUT);

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (&v) ? v : v + IDLE_W'(1);
    endfunction

    pk_state_e         state_q, state_d;
    logic [55:0]       res_data_q, res_data_d;
    logic [2:0]        res_cnt_q, res_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [31:0]       seg_count_q;
    logic              keep_err_q;

    logic              out_free;
    logic              accept;
    logic              timeout_hit;
    logic              flush_req;
    logic [3:0]        n_bytes;
    logic [3:0]        total;
    logic [7:0]        byte_mask;
    logic [63:0]       tdata_masked;
    logic [119:0]      combined;
    logic              ld;
    logic [63:0]       ld_data;
    logic [7:0]        ld_keep;
    logic              ld_last;

    assign app_axis_tready = s_aresetn && (state_q == ST_RUN) && out_free;
    assign accept          = app_axis_tvalid && app_axis_tready;
    assign seg_count       = seg_count_q;
    assign keep_err        = keep_err_q;

    // Stage p0: merge accepted bytes onto the residue and decide the next beat
    always_comb begin
        n_bytes   = keep_count(app_axis_tkeep);
        byte_mask = count_to_keep(n_bytes);
        for (int i = 0; i < 8; i++) begin
            tdata_masked[8*i +: 8] = byte_mask[i] ? app_axis_tdata[8*i +: 8] : 8'h00;
        end
        combined    = {64'h0, res_data_q} | ({56'h0, tdata_masked} << {res_cnt_q, 3'b000});
        total       = {1'b0, res_cnt_q} + n_bytes;
        timeout_hit = (FLUSH_TIMEOUT != 0) && (state_q == ST_RUN) && (idle_cnt_q == IDLE_LIMIT);
        flush_req   = (accept && app_axis_tlast) || timeout_hit;

        state_d    = state_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        beat_cnt_d = beat_cnt_q;
        ld         = 1'b0;
        ld_data    = combined[63:0];
        ld_keep    = 8'hFF;
        ld_last    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (total >= 4'd8) begin
                        ld         = 1'b1;
                        res_data_d = combined[119:64];
                        res_cnt_d  = 3'(total - 4'd8);
                        ld_last    = (beat_cnt_q == BEAT_LAST) || (flush_req && res_cnt_d == 3'd0);
                    end else begin
                        res_data_d = combined[55:0];
                        res_cnt_d  = total[2:0];
                    end
                end
                if (ld) begin
                    beat_cnt_d = ld_last ? '0 : beat_cnt_q + BEAT_W'(1);
                end
                if (flush_req && res_cnt_d != 3'd0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    ld         = 1'b1;
                    ld_data    = {8'h00, res_data_q};
                    ld_keep    = count_to_keep({1'b0, res_cnt_q});
                    ld_last    = 1'b1;
                    res_data_d = '0;
                    res_cnt_d  = 3'd0;
                    beat_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (state_q == ST_RUN && !accept && !flush_req && res_cnt_q != 3'd0) begin
            idle_cnt_d = sat_inc(idle_cnt_q);
        end else begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q     <= ST_RUN;
            res_data_q  <= '0;
            res_cnt_q   <= 3'd0;
            beat_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            seg_count_q <= 32'd0;
            keep_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                seg_count_q <= seg_count_q + 32'd1;
            end
            if (accept && !keep_contig(app_axis_tkeep)) begin
                keep_err_q <= 1'b1;
            end
        end
    end

    // Stage p1: registered output beat
    tcp_axis_out_reg #(
        .DATA_W(64)
    ) u_out_reg (
        .s_aclk       (s_aclk),
        .s_aresetn    (s_aresetn),
        .load         (ld),
        .ld_data      (ld_data),
        .ld_keep      (ld_keep),
        .ld_last      (ld_last),
        .free         (out_free),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast)
    );

endmodule

// File: tb/tb_tcp_tx_byte_packer.sv
// Scoreboard bench for tcp_tx_byte_packer: byte-queue reference model feeds
// expected beats; a negedge monitor pops and compares handshaked beats.
module tb_tcp_tx_byte_packer;

    localparam int TDL = 1456;
    localparam int TO  = 4;
    localparam int SEG = TDL / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        app_valid = 1'b0;
    logic        app_ready;
    logic [63:0] app_data = '0;
    logic [7:0]  app_keep = '0;
    logic        app_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last;
    logic [31:0] seg_count;
    logic        keep_err;

    always #5 clk = ~clk;

    tcp_tx_byte_packer #(
        .TCP_DATA_LENGTH(TDL),
        .FLUSH_TIMEOUT  (TO)
    ) dut (
        .s_aclk         (clk),
        .s_aresetn      (rst_n),
        .app_axis_tvalid(app_valid),
        .app_axis_tready(app_ready),
        .app_axis_tdata (app_data),
        .app_axis_tkeep (app_keep),
        .app_axis_tlast (app_last),
        .m_axis_tvalid  (m_valid),
        .m_axis_tready  (m_ready),
        .m_axis_tdata   (m_data),
        .m_axis_tkeep   (m_keep),
        .m_axis_tlast   (m_last),
        .seg_count      (seg_count),
        .keep_err       (keep_err)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    int checks = 0;
    int passes = 0;
    int stalls = 0;

    logic [7:0] bq[$];
    beat_t      exp_q[$];
    int         mbeat = 0;
    int         msegs = 0;
    bit         mkerr = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: bytes form one ordered stream; every 8 make a dense beat,
    // segments close after SEG beats, a flush request closes out the residue.
    task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input bit last);
        int    n;
        beat_t b;
        bit    emit;
        logic [8:0] k9;
        n    = $countones(k);
        emit = 1'b0;
        k9   = {1'b0, k};
        if ((k9 & (k9 + 9'd1)) != 9'd0) mkerr = 1'b1;
        for (int i = 0; i < n; i++) bq.push_back(d[8*i +: 8]);
        b.d = '0; b.k = '0; b.l = 1'b0;
        if (bq.size() >= 8) begin
            for (int i = 0; i < 8; i++) b.d[8*i +: 8] = bq.pop_front();
            b.k  = 8'hFF;
            b.l  = (mbeat == SEG - 1);
            emit = 1'b1;
        end
        if (emit && last && bq.size() == 0) b.l = 1'b1;
        if (emit) begin
            exp_q.push_back(b);
            mbeat = b.l ? 0 : mbeat + 1;
            if (b.l) msegs++;
        end
        if (last && bq.size() != 0) begin
            b.d = '0; b.k = '0; b.l = 1'b1;
            for (int i = 0; bq.size() != 0; i++) begin
                b.d[8*i +: 8] = bq.pop_front();
                b.k[i] = 1'b1;
            end
            exp_q.push_back(b);
            mbeat = 0;
            msegs++;
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random with short stalls, 2 = blocked
    int ready_mode = 0;
    int low_run = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            2: m_ready = 1'b0;
            default: begin
                if (low_run >= 2) m_ready = 1'b1;
                else m_ready = 1'($urandom_range(0, 1));
                low_run = m_ready ? 0 : low_run + 1;
            end
        endcase
    end

    bit          held = 1'b0;
    beat_t       hb;
    beat_t       mon_b;
    logic [63:0] mon_mask;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk(m_valid && m_data == hb.d && m_keep == hb.k && m_last == hb.l,
                    "stall_hold", m_data, hb.d);
            end
            if (m_valid && m_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", m_data, 64'h0);
                end else begin
                    mon_b = exp_q.pop_front();
                    for (int i = 0; i < 8; i++) mon_mask[8*i +: 8] = {8{mon_b.k[i]}};
                    chk((m_data & mon_mask) == mon_b.d, "beat_data", m_data & mon_mask, mon_b.d);
                    chk(m_keep == mon_b.k, "beat_keep", 64'(m_keep), 64'(mon_b.k));
                    chk(m_last == mon_b.l, "beat_last", 64'(m_last), 64'(mon_b.l));
                end
            end else if (m_valid) begin
                held = 1'b1;
                hb.d = m_data; hb.k = m_keep; hb.l = m_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        app_valid = 1'b1; app_data = d; app_keep = k; app_last = last;
        forever begin
            @(negedge clk);
            if (app_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            t++;
            if (t > 1000) begin
                chk(1'b0, "accept_timeout", 64'h0, 64'h1);
                break;
            end
        end
        if (ok) model_accept(d, k, last);
        @(posedge clk);
        #1;
        app_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(exp_q.size() == 0 && !m_valid, name, 64'(exp_q.size()), 64'h0);
    endtask

    task automatic send_dense_segment(input bit check_latency);
        logic [63:0] d;
        for (int i = 0; i < SEG; i++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'((8 * i + j) & 255);
            send_beat(d, 8'hFF, 1'b0);
            if (check_latency && i == 0) chk(m_valid == 1'b1, "latency_1", 64'(m_valid), 64'h1);
        end
    endtask

    initial begin
        int          c;
        logic [63:0] d;
        logic [7:0]  k;
        logic [15:0] m16;
        bit          last;

        repeat (3) @(posedge clk);
        #1;
        chk(m_valid == 1'b0, "rst_tvalid", 64'(m_valid), 64'h0);
        chk(m_data == 64'h0, "rst_tdata", m_data, 64'h0);
        chk(m_keep == 8'h0 && m_last == 1'b0, "rst_tkeep_tlast", 64'({m_keep, m_last}), 64'h0);
        chk(seg_count == 32'd0, "rst_seg_count", 64'(seg_count), 64'h0);
        chk(keep_err == 1'b0, "rst_keep_err", 64'(keep_err), 64'h0);
        chk(app_ready == 1'b0, "rst_app_ready", 64'(app_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(app_ready == 1'b1, "ready_after_reset", 64'(app_ready), 64'h1);

        // Dense segment
        stalls = 0;
        send_dense_segment(1'b1);
        chk(stalls == 0, "dense_throughput", 64'(stalls), 64'h0);
        wait_drain("drain_dense");
        chk(seg_count == 32'd1, "seg_count_dense", 64'(seg_count), 64'h1);

        // Single-byte beats pack into dense beats
        for (int i = 0; i < 16; i++) send_beat({56'h0, 8'(i)}, 8'h01, 1'b0);
        wait_drain("drain_single_bytes");
        chk(seg_count == 32'(msegs), "seg_count_single", 64'(seg_count), 64'(msegs));

        // tlast with residue forces a flush and one app stall
        send_beat({$urandom, $urandom}, 8'h1F, 1'b0);
        send_beat({$urandom, $urandom}, 8'h3F, 1'b1);
        @(negedge clk);
        chk(app_ready == 1'b0, "flush_stall", 64'(app_ready), 64'h0);
        @(negedge clk);
        chk(app_ready == 1'b1, "flush_resume", 64'(app_ready), 64'h1);
        wait_drain("drain_tlast_flush");
        chk(seg_count == 32'(msegs), "seg_count_flush", 64'(seg_count), 64'(msegs));

        // Empty tlast with no residue produces nothing
        send_beat(64'h0, 8'h00, 1'b1);
        wait_drain("drain_empty_tlast");

        // Idle timeout flush
        send_beat({$urandom, $urandom}, 8'h07, 1'b0);
        model_accept(64'h0, 8'h00, 1'b1);
        c = 0;
        while (!m_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(c == 6, "timeout_latency", 64'(c), 64'd6);
        wait_drain("drain_timeout");
        chk(seg_count == 32'(msegs), "seg_count_timeout", 64'(seg_count), 64'(msegs));
        chk(keep_err == 1'b0, "keep_err_clean", 64'(keep_err), 64'h0);

        // Random keeps with random downstream stalls
        ready_mode = 1;
        for (int i = 0; i < 500; i++) begin
            d = {$urandom, $urandom};
            if (i == 100) begin
                k = 8'h05;
            end else if ($urandom_range(0, 9) == 0) begin
                k = 8'($urandom);
            end else begin
                m16 = (16'd1 << $urandom_range(0, 8)) - 16'd1;
                k = m16[7:0];
            end
            last = (i == 499) || ($urandom_range(0, 19) == 0);
            send_beat(d, k, last);
        end
        ready_mode = 0;
        wait_drain("drain_random");
        chk(seg_count == 32'(msegs), "seg_count_random", 64'(seg_count), 64'(msegs));
        chk(keep_err == mkerr, "keep_err_random", 64'(keep_err), 64'(mkerr));

        // Reset with residue 5 and a blocked pending beat
        ready_mode = 2;
        @(posedge clk);
        #1;
        send_beat({$urandom, $urandom}, 8'h1F, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        chk(m_valid == 1'b1, "pending_before_reset", 64'(m_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk(m_valid == 1'b0 && m_last == 1'b0, "midrst_tvalid_tlast", 64'({m_valid, m_last}), 64'h0);
        chk(m_data == 64'h0 && m_keep == 8'h0, "midrst_tdata_tkeep", m_data, 64'h0);
        chk(seg_count == 32'd0, "midrst_seg_count", 64'(seg_count), 64'h0);
        chk(keep_err == 1'b0, "midrst_keep_err", 64'(keep_err), 64'h0);
        chk(app_ready == 1'b0, "midrst_app_ready", 64'(app_ready), 64'h0);
        exp_q.delete();
        bq.delete();
        mbeat = 0;
        msegs = 0;
        mkerr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        send_dense_segment(1'b0);
        wait_drain("drain_after_reset");
        chk(seg_count == 32'd1, "seg_count_after_reset", 64'(seg_count), 64'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
